// File: rtl/alu_muldiv_seq_pkg.sv
// Opcode constants, engine FSM encoding and opcode classification for alu_muldiv_seq.
// ALU_DIV_EN selects whether div/divu are accepted by the iterative engine.
package alu_pkg;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_NOR   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_e;

  // Opcodes that launch the iterative engine when start is seen in IDLE.
  function automatic logic op_is_md(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction
endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Execute-stage ALU bus: operands/opcode/start from the core, result and HI/LO engine status back.
interface alu_muldiv_seq_if #(parameter int W = 32);
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   AluOp;
  logic         start;
  logic [W-1:0] Result;
  logic         zero;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (output A, B, AluOp, start, input Result, zero, busy, done, hi, lo);
  modport slave  (input A, B, AluOp, start, output Result, zero, busy, done, hi, lo);
endinterface

// File: rtl/alu_muldiv_seq_muldiv_iter.sv
// Iterative multiply/divide engine on unsigned magnitudes with a final sign fix-up cycle.
// Divider datapath is only built when ALU_DIV_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_op,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_a, r_b, r_m;
  logic [3:0]       r_op;
  logic [2*W-1:0]   r_acc;
  logic             r_done_pend;

  logic         w_in_signed, w_in_mul;
  logic [W-1:0] w_in_ma, w_in_mb;
  assign w_in_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_in_mul    = ~i_op[1];
  assign w_in_ma     = (w_in_signed && i_a[W-1]) ? -i_a : i_a;
  assign w_in_mb     = (w_in_signed && i_b[W-1]) ? -i_b : i_b;

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_mul_nxt, w_prod;
  logic           w_signed, w_neg;
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_m} : {(W+1){1'b0}});
  assign w_mul_nxt = {w_sum, r_acc[W-1:1]};
  assign w_signed  = (r_op == OP_MULT) || (r_op == OP_DIV);
  assign w_neg     = w_signed && (r_a[W-1] ^ r_b[W-1]);
  assign w_prod    = w_neg ? -r_acc : r_acc;

`ifdef ALU_DIV_EN
  // Restoring step: acc = {partial remainder, dividend bits / quotient bits}.
  logic [W:0]     w_top;
  logic           w_ge;
  logic [W-1:0]   w_trial, w_rem, w_q, w_r;
  logic [2*W-1:0] w_div_nxt;
  assign w_top     = r_acc[2*W-1:W-1];
  assign w_ge      = w_top >= {1'b0, r_m};
  assign w_trial   = w_top[W-1:0] - r_m;
  assign w_rem     = w_ge ? w_trial : w_top[W-1:0];
  assign w_div_nxt = {w_rem, r_acc[W-2:0], w_ge};
  assign w_q       = w_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_r       = (w_signed && r_a[W-1]) ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_m         <= '0;
      r_op        <= '0;
      r_acc       <= '0;
      r_done_pend <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_hi        <= '0;
      o_lo        <= '0;
    end else begin
      o_done      <= r_done_pend;
      r_done_pend <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start && op_is_md(i_op)) begin
          r_a     <= i_a;
          r_b     <= i_b;
          r_op    <= i_op;
          r_m     <= w_in_mul ? w_in_ma : w_in_mb;
          r_acc   <= {{W{1'b0}}, (w_in_mul ? w_in_mb : w_in_ma)};
          r_cnt   <= '0;
          r_state <= S_RUN;
          o_busy  <= 1'b1;
        end
        S_RUN: begin
`ifdef ALU_DIV_EN
          r_acc <= r_op[1] ? w_div_nxt : w_mul_nxt;
`else
          r_acc <= w_mul_nxt;
`endif
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
`ifdef ALU_DIV_EN
          if (!r_op[1]) {o_hi, o_lo} <= w_prod;
          else if (r_b == '0) begin
            o_hi <= r_a;
            o_lo <= '1;
          end else begin
            o_hi <= w_r;
            o_lo <= w_q;
          end
`else
          {o_hi, o_lo} <= w_prod;
`endif
          r_state     <= S_IDLE;
          o_busy      <= 1'b0;
          r_done_pend <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Execute-stage ALU: combinational single-cycle ops plus HI/LO read-back from the muldiv_iter engine.
// Divide support follows ALU_DIV_EN (see muldiv_iter).
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W) + 1
) (
  input logic            clk,
  input logic            reset,
  alu_muldiv_seq_if.slave bus
);
  logic [W-1:0] w_hi, w_lo, w_result;
  logic         w_busy, w_done;

  muldiv_iter #(.W(W), .CNT_W(CNT_W)) u_muldiv (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_a    (bus.A),
    .i_b    (bus.B),
    .i_op   (bus.AluOp),
    .i_start(bus.start),
    .o_busy (w_busy),
    .o_done (w_done),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  // mfhi/mflo read the registers directly, so they may show stale values while busy.
  always_comb begin
    w_result = '0;
    case (bus.AluOp)
      OP_ADD:  w_result = bus.A + bus.B;
      OP_SUB:  w_result = bus.A - bus.B;
      OP_SLT:  w_result = {{(W-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU: w_result = {{(W-1){1'b0}}, bus.A < bus.B};
      OP_AND:  w_result = bus.A & bus.B;
      OP_OR:   w_result = bus.A | bus.B;
      OP_NOR:  w_result = ~(bus.A | bus.B);
      OP_XOR:  w_result = bus.A ^ bus.B;
      OP_MFHI: w_result = w_hi;
      OP_MFLO: w_result = w_lo;
      default: w_result = '0;
    endcase
  end

  assign bus.Result = w_result;
  assign bus.zero   = ~|w_result;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.hi     = w_hi;
  assign bus.lo     = w_lo;
endmodule
